pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
- Downstream consumer of the pattern buffer bank.
- Drives the bank's buffer select (bufp) and field pointer (fieldp), and captures the returned field_byte.
- Streams a configured window of bytes from one buffer, repeated a programmed number of times, onto a valid/ready pattern output port.
- Feeds the pattern output stage, with one byte accepted per handshake.

Parameters:
- BUF_WIDTH, 8: width of one buffer byte and of pat_data.
- BUF_SIZE, 32: bytes per buffer; fieldp width is log2(BUF_SIZE) = 5.
- NO_BUFS, 8: number of buffers; bufp width is log2(NO_BUFS) = 3.
- LOOP_W, 8: width of the loop count and loop counter.

Ports:
- clk  input  1  sequencer clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a run using the cfg_* values.
- abort  input  1  terminates a run immediately.
- cfg_buf  input  3  buffer to play.
- cfg_first  input  5  first field index of the window.
- cfg_last  input  5  last field index of the window (inclusive).
- cfg_loops  input  LOOP_W  number of window passes; 0 = repeat until abort.
- bufp  output  3  buffer select to the bank (registered).
- fieldp  output  5  field pointer to the bank (registered).
- field_byte  input  BUF_WIDTH  combinational byte returned by the bank for bufp/fieldp.
- pat_data  output  BUF_WIDTH  pattern byte (registered).
- pat_valid  output  1  pat_data holds a valid byte.
- pat_ready  input  1  downstream accepts pat_data.
- pat_last  output  1  pat_data is the final byte of the run.
- loop_cnt  output  LOOP_W  completed window passes.
- busy  output  1  high outside IDLE.
- done  output  1  one-cycle pulse when a run finishes normally.
- cfg_err  output  1  one-cycle pulse when start is rejected for cfg_first > cfg_last.

Behaviour:
- Reset values: bufp, fieldp, pat_data, pat_valid, pat_last, loop_cnt, busy, done and cfg_err are all 0; state is IDLE.
- Reset mid-run aborts immediately; no done pulse is produced.
- States: IDLE, PRIME, RUN, FINISH.
- IDLE, start=1, cfg_first<=cfg_last:
  - latch the cfg_* values;
  - set bufp=cfg_buf, fieldp=cfg_first, loop_cnt=0;
  - go to PRIME.
- IDLE, start=1, cfg_first>cfg_last: pulse cfg_err and stay in IDLE.
- start while not IDLE is ignored.
- PRIME (one cycle):
  - pat_data<=field_byte; pat_valid<=1;
  - pat_last<=(fieldp==last && loops==1);
  - advance the pointer;
  - go to RUN.
- Pointer advance:
  - if fieldp==last: fieldp<=first, loop_cnt<=loop_cnt+1 (saturating at max);
  - else fieldp<=fieldp+1.
- RUN, pat_valid && pat_ready && !pat_last:
  - pat_data<=field_byte (the next index is already on fieldp);
  - pat_last<=(fieldp==last && loop_cnt==loops-1 && loops!=0);
  - advance the pointer.
- RUN, pat_valid && pat_ready && pat_last: pat_valid<=0, pat_last<=0, go to FINISH.
- RUN, pat_ready=0: pat_data, pat_valid, pat_last and fieldp all hold stable.
- FINISH (one cycle): done=1, then IDLE. bufp and loop_cnt hold their final values until the next start.
- Throughput: one byte per cycle while pat_ready=1. First pat_valid rises 2 cycles after start.
- loops=0: pat_last is never set; the window wraps forever; loop_cnt saturates at 2^LOOP_W-1.
- abort (any state except IDLE): next cycle pat_valid=0, pat_last=0, state=IDLE. No done pulse. Priority: abort over the handshake; reset over everything.
- Single-element window (first==last): the same byte is emitted each pass; loop_cnt increments every byte.
- The block does not observe scan loading of the bank. Contents must be stable while busy=1.

Test Plan:
1. Buffer 3 preloaded with bytes 0x10+i; first=4, last=7, loops=1, pat_ready=1 -> 0x14,0x15,0x16,0x17 on consecutive cycles; pat_last on 0x17; done one cycle after its handshake; loop_cnt=1.
2. first=0, last=2, loops=3, pat_ready toggled 1/0 each cycle -> nine bytes 0x10,0x11,0x12 repeated 3 times; data stable while pat_ready=0; loop_cnt=3; pat_last only on the ninth byte.
3. loops=0, first=last=31 -> byte 31 repeated indefinitely with no pat_last; abort after 10 bytes -> pat_valid=0 next cycle; IDLE; no done.
4. start with first=9, last=5 -> cfg_err pulse; busy stays 0; no pat_valid.
5. rst_n asserted asynchronously mid-RUN -> all outputs 0 immediately; a subsequent start runs normally.
6. start asserted while busy=1 with a different cfg_buf -> ignored; the original stream completes unchanged.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Pattern sequencer: plays a window of one pattern-bank buffer, repeated a
// programmed number of times, onto a valid/ready byte stream.
`timescale 1ns/1ps

module pattern_sequencer #(
    parameter  int unsigned BUF_WIDTH = 8,
    parameter  int unsigned BUF_SIZE  = 32,
    parameter  int unsigned NO_BUFS   = 8,
    parameter  int unsigned LOOP_W    = 8,
    localparam int unsigned FP_W      = $clog2(BUF_SIZE),
    localparam int unsigned BP_W      = $clog2(NO_BUFS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [BP_W-1:0]      cfg_buf,
    input  logic [FP_W-1:0]      cfg_first,
    input  logic [FP_W-1:0]      cfg_last,
    input  logic [LOOP_W-1:0]    cfg_loops,
    output logic [BP_W-1:0]      bufp,
    output logic [FP_W-1:0]      fieldp,
    input  logic [BUF_WIDTH-1:0] field_byte,
    output logic [BUF_WIDTH-1:0] pat_data,
    output logic                 pat_valid,
    input  logic                 pat_ready,
    output logic                 pat_last,
    output logic [LOOP_W-1:0]    loop_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t               r_state;
    logic [FP_W-1:0]      r_first;
    logic [FP_W-1:0]      r_last;
    logic [LOOP_W-1:0]    r_loops;
    logic [BP_W-1:0]      r_bufp;
    logic [FP_W-1:0]      r_fieldp;
    logic [BUF_WIDTH-1:0] r_pat_data;
    logic                 r_pat_valid;
    logic                 r_pat_last;
    logic [LOOP_W-1:0]    r_loop_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_cfg_err;

    logic                 w_at_last;
    logic [LOOP_W-1:0]    w_lc_inc;
    logic [FP_W-1:0]      w_fp_next;
    logic [LOOP_W-1:0]    w_lc_next;
    logic                 w_last_prime;
    logic                 w_last_run;

    // Pointer advance: wrap to the window start and count a completed pass (saturating)
    assign w_at_last    = (r_fieldp == r_last);
    assign w_lc_inc     = (r_loop_cnt == {LOOP_W{1'b1}}) ? r_loop_cnt : r_loop_cnt + LOOP_W'(1);
    assign w_fp_next    = w_at_last ? r_first : r_fieldp + FP_W'(1);
    assign w_lc_next    = w_at_last ? w_lc_inc : r_loop_cnt;
    // Byte being loaded closes the final pass of a finite run
    assign w_last_prime = w_at_last && (r_loops == LOOP_W'(1));
    assign w_last_run   = w_at_last && (r_loop_cnt == r_loops - LOOP_W'(1)) && (r_loops != '0);

    // Sequencer FSM with registered outputs; abort beats the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_first     <= '0;
            r_last      <= '0;
            r_loops     <= '0;
            r_bufp      <= '0;
            r_fieldp    <= '0;
            r_pat_data  <= '0;
            r_pat_valid <= 1'b0;
            r_pat_last  <= 1'b0;
            r_loop_cnt  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                r_pat_valid <= 1'b0;
                r_pat_last  <= 1'b0;
                r_busy      <= 1'b0;
                r_state     <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (cfg_first <= cfg_last) begin
                                r_first    <= cfg_first;
                                r_last     <= cfg_last;
                                r_loops    <= cfg_loops;
                                r_bufp     <= cfg_buf;
                                r_fieldp   <= cfg_first;
                                r_loop_cnt <= '0;
                                r_busy     <= 1'b1;
                                r_state    <= S_PRIME;
                            end else begin
                                r_cfg_err  <= 1'b1;
                            end
                        end
                    end
                    S_PRIME: begin
                        r_pat_data  <= field_byte;
                        r_pat_valid <= 1'b1;
                        r_pat_last  <= w_last_prime;
                        r_fieldp    <= w_fp_next;
                        r_loop_cnt  <= w_lc_next;
                        r_state     <= S_RUN;
                    end
                    S_RUN: begin
                        if (r_pat_valid && pat_ready) begin
                            if (r_pat_last) begin
                                r_pat_valid <= 1'b0;
                                r_pat_last  <= 1'b0;
                                r_done      <= 1'b1;
                                r_state     <= S_FINISH;
                            end else begin
                                r_pat_data  <= field_byte;
                                r_pat_last  <= w_last_run;
                                r_fieldp    <= w_fp_next;
                                r_loop_cnt  <= w_lc_next;
                            end
                        end
                    end
                    S_FINISH: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bufp      = r_bufp;
    assign fieldp    = r_fieldp;
    assign pat_data  = r_pat_data;
    assign pat_valid = r_pat_valid;
    assign pat_last  = r_pat_last;
    assign loop_cnt  = r_loop_cnt;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: bank model, table-driven runs, corner sequences, random runs.
`timescale 1ns/1ps

module tb_pattern_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] cfg_buf;
    logic [4:0] cfg_first;
    logic [4:0] cfg_last;
    logic [7:0] cfg_loops;
    logic [2:0] bufp;
    logic [4:0] fieldp;
    logic [7:0] field_byte;
    logic [7:0] pat_data;
    logic       pat_valid;
    logic       pat_ready;
    logic       pat_last;
    logic [7:0] loop_cnt;
    logic       busy;
    logic       done;
    logic       cfg_err;

    logic [7:0] mem [8][32];

    int n_tests = 0;
    int n_fail  = 0;

    pattern_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_buf    (cfg_buf),
        .cfg_first  (cfg_first),
        .cfg_last   (cfg_last),
        .cfg_loops  (cfg_loops),
        .bufp       (bufp),
        .fieldp     (fieldp),
        .field_byte (field_byte),
        .pat_data   (pat_data),
        .pat_valid  (pat_valid),
        .pat_ready  (pat_ready),
        .pat_last   (pat_last),
        .loop_cnt   (loop_cnt),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    // Pattern bank model: combinational read
    assign field_byte = mem[bufp][fieldp];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0] b;
        logic [4:0] f;
        logic [4:0] l;
        logic [7:0] lp;
        int         rmode;
        bit         exp_err;
        logic [7:0] exp_lc;
    } vec_t;

    // One run: expected stream is the window repeated lp times (lp=0: forever)
    task automatic do_run(input logic [2:0] b, input logic [4:0] f, input logic [4:0] l,
                          input logic [7:0] lp, input int rmode, input bit exp_err,
                          input logic [7:0] exp_lc, input int start_at, input int abort_after);
        int         len, total, k, cyc, budget;
        bit         hold, fin;
        logic [7:0] h_data;
        logic       h_last;
        logic [7:0] exp_byte;
        len    = int'(l) - int'(f) + 1;
        total  = int'(lp) * len;
        budget = 20 * ((lp == 0) ? abort_after : total) + 100;
        @(negedge clk);
        cfg_buf = b; cfg_first = f; cfg_last = l; cfg_loops = lp;
        start = 1'b1; pat_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (exp_err) begin
            check("err_pulse", 32'(cfg_err), 1);
            check("err_busy", 32'(busy), 0);
            repeat (3) begin
                @(negedge clk);
                check("err_pulse_end", 32'(cfg_err), 0);
                check("err_no_valid", 32'(pat_valid), 0);
                check("err_busy_low", 32'(busy), 0);
            end
            return;
        end
        check("prime_busy", 32'(busy), 1);
        check("prime_valid", 32'(pat_valid), 0);
        check("prime_bufp", 32'(bufp), 32'(b));
        check("prime_fieldp", 32'(fieldp), 32'(f));
        check("prime_loopcnt", 32'(loop_cnt), 0);
        k = 0; cyc = 0; hold = 0; fin = 0;
        while (!fin && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) check("first_valid_latency", 32'(pat_valid), 1);
            if (hold) begin
                check("stall_valid", 32'(pat_valid), 1);
                check("stall_data", 32'(pat_data), 32'(h_data));
                check("stall_last", 32'(pat_last), 32'(h_last));
            end
            check("bufp_stable", 32'(bufp), 32'(b));
            if (cyc == start_at) begin
                start = 1'b1; cfg_buf = b + 3'd1; cfg_first = 5'd0; cfg_last = 5'd31; cfg_loops = 8'd1;
            end
            if (abort_after >= 0 && k == abort_after) begin
                abort = 1'b1; pat_ready = 1'b1;
                @(negedge clk);
                abort = 1'b0; start = 1'b0;
                check("abort_valid", 32'(pat_valid), 0);
                check("abort_last", 32'(pat_last), 0);
                check("abort_busy", 32'(busy), 0);
                check("abort_no_done", 32'(done), 0);
                check("abort_loopcnt", 32'(loop_cnt), 32'(exp_lc));
                @(negedge clk);
                check("abort_no_done2", 32'(done), 0);
                check("abort_idle", 32'(busy), 0);
                fin = 1;
            end else begin
                case (rmode)
                    0:       pat_ready = 1'b1;
                    1:       pat_ready = (cyc % 2 == 1);
                    default: pat_ready = 1'($urandom_range(0, 1));
                endcase
                hold   = pat_valid && !pat_ready;
                h_data = pat_data;
                h_last = pat_last;
                if (pat_valid && pat_ready) begin
                    exp_byte = mem[b][int'(f) + (k % len)];
                    check("byte_data", 32'(pat_data), 32'(exp_byte));
                    check("byte_last", 32'(pat_last), 32'((lp != 0) && (k == total - 1)));
                    k++;
                    if (lp != 0 && k == total) begin
                        @(negedge clk);
                        start = 1'b0;
                        check("done_pulse", 32'(done), 1);
                        check("finish_valid", 32'(pat_valid), 0);
                        check("finish_last", 32'(pat_last), 0);
                        check("finish_busy", 32'(busy), 1);
                        check("finish_loopcnt", 32'(loop_cnt), 32'(exp_lc));
                        @(negedge clk);
                        check("done_one_cycle", 32'(done), 0);
                        check("idle_busy", 32'(busy), 0);
                        check("idle_loopcnt_hold", 32'(loop_cnt), 32'(exp_lc));
                        check("idle_bufp_hold", 32'(bufp), 32'(b));
                        fin = 1;
                    end
                end
            end
        end
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_timeout: got %0d bytes in %0d cycles, required completion", k, cyc);
        end
        pat_ready = 1'b0;
        start     = 1'b0;
    endtask

    vec_t tbl [7];

    initial begin
        tbl[0] = '{b: 3'd3, f: 5'd4,  l: 5'd7,  lp: 8'd1,   rmode: 0, exp_err: 0, exp_lc: 8'd1};
        tbl[1] = '{b: 3'd3, f: 5'd0,  l: 5'd2,  lp: 8'd3,   rmode: 1, exp_err: 0, exp_lc: 8'd3};
        tbl[2] = '{b: 3'd3, f: 5'd9,  l: 5'd5,  lp: 8'd1,   rmode: 0, exp_err: 1, exp_lc: 8'd0};
        tbl[3] = '{b: 3'd3, f: 5'd31, l: 5'd31, lp: 8'd1,   rmode: 0, exp_err: 0, exp_lc: 8'd1};
        tbl[4] = '{b: 3'd5, f: 5'd0,  l: 5'd31, lp: 8'd2,   rmode: 2, exp_err: 0, exp_lc: 8'd2};
        tbl[5] = '{b: 3'd0, f: 5'd0,  l: 5'd0,  lp: 8'd4,   rmode: 0, exp_err: 0, exp_lc: 8'd4};
        tbl[6] = '{b: 3'd7, f: 5'd10, l: 5'd11, lp: 8'd255, rmode: 0, exp_err: 0, exp_lc: 8'd255};

        for (int bb = 0; bb < 8; bb++)
            for (int i = 0; i < 32; i++)
                mem[bb][i] = (bb == 3) ? 8'(8'h10 + i) : 8'($urandom);

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pat_ready = 1'b0;
        cfg_buf = '0; cfg_first = '0; cfg_last = '0; cfg_loops = '0;
        repeat (2) @(negedge clk);
        check("rst_bufp", 32'(bufp), 0);
        check("rst_fieldp", 32'(fieldp), 0);
        check("rst_data", 32'(pat_data), 0);
        check("rst_valid", 32'(pat_valid), 0);
        check("rst_last", 32'(pat_last), 0);
        check("rst_loopcnt", 32'(loop_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        rst_n = 1'b1;

        for (int t = 0; t < 7; t++)
            do_run(tbl[t].b, tbl[t].f, tbl[t].l, tbl[t].lp, tbl[t].rmode,
                   tbl[t].exp_err, tbl[t].exp_lc, -1, -1);

        // Endless single-element window, aborted after 10 bytes (11 loaded)
        do_run(3'd3, 5'd31, 5'd31, 8'd0, 0, 0, 8'd11, -1, 10);
        // Pass counter saturation on an endless run
        do_run(3'd1, 5'd0, 5'd0, 8'd0, 0, 0, 8'd255, -1, 300);
        // Start while busy with a different buffer must be ignored
        do_run(3'd3, 5'd0, 5'd5, 8'd2, 1, 0, 8'd2, 4, -1);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        cfg_buf = 3'd3; cfg_first = 5'd0; cfg_last = 5'd7; cfg_loops = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; pat_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_valid", 32'(pat_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(pat_valid), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_data", 32'(pat_data), 0);
        check("async_rst_bufp", 32'(bufp), 0);
        check("async_rst_fieldp", 32'(fieldp), 0);
        check("async_rst_loopcnt", 32'(loop_cnt), 0);
        check("async_rst_last", 32'(pat_last), 0);
        @(negedge clk);
        rst_n = 1'b1; pat_ready = 1'b0;
        @(negedge clk);
        check("post_rst_no_done", 32'(done), 0);
        do_run(3'd3, 5'd4, 5'd7, 8'd1, 0, 0, 8'd1, -1, -1);

        // Random windows, loop counts and backpressure
        for (int r = 0; r < 10; r++) begin
            logic [2:0] rb;
            logic [4:0] rf, rl;
            logic [7:0] rlp;
            rb  = 3'($urandom_range(0, 7));
            rf  = 5'($urandom_range(0, 31));
            rl  = 5'($urandom_range(int'(rf), 31));
            rlp = 8'($urandom_range(1, 3));
            do_run(rb, rf, rl, rlp, 2, 0, rlp, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
